// File: rtl/next_pc_unit.sv
// Next-PC selection for the fetch stage: sequential, branch, register-indirect and
// memory-indirect targets, plus the N/Z status flags that conditional branches test.
module next_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [2:0]  status,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        flag_we,
   input  logic [31:0] imm,
   input  logic [31:0] rs_data,
   input  logic [31:0] mem_data,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        taken,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic        flag_n,
   output logic        flag_z
);

   localparam logic [2:0] ST_SEQ   = 3'b000;
   localparam logic [2:0] ST_BMN   = 3'b001;
   localparam logic [2:0] ST_BRZ   = 3'b010;
   localparam logic [2:0] ST_BZ    = 3'b011;
   localparam logic [2:0] ST_JMOR  = 3'b100;
   localparam logic [2:0] ST_JALM  = 3'b101;
   localparam logic [2:0] ST_JSPAL = 3'b110;
   localparam logic [2:0] ST_BEQ   = 3'b111;

   logic [31:0] pc_q, pc_d;
   logic        flag_n_q, flag_n_d;
   logic        flag_z_q, flag_z_d;
   logic [31:0] brTarget;
   logic [31:0] rsTarget;
   logic [31:0] memTarget;
   logic        takenSel;

   assign pc_plus4  = pc_q + 32'd4;
   assign brTarget  = pc_plus4 + {imm[29:0], 2'b00};
   assign rsTarget  = {rs_data[31:2], 2'b00};
   assign memTarget = {mem_data[31:2], 2'b00};

   // Conditional branches look at the flags as registered before this edge,
   // so a flag update carried by the same instruction cannot affect its own branch.
   always_comb begin
      takenSel = 1'b0;
      pc_d     = pc_plus4;
      case (status)
         ST_BEQ:   takenSel = alu_zero;
         ST_BMN:   takenSel = flag_n_q;
         ST_BRZ:   takenSel = flag_z_q;
         ST_BZ:    takenSel = flag_z_q;
         ST_JMOR, ST_JALM, ST_JSPAL: takenSel = 1'b1;
         default:  takenSel = 1'b0;
      endcase
      if (takenSel) begin
         case (status)
            ST_BEQ, ST_BZ: pc_d = brTarget;
            ST_BRZ:        pc_d = rsTarget;
            default:       pc_d = memTarget;
         endcase
      end
   end

   always_comb begin
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      if (flag_we) begin
         flag_n_d = alu_result[31];
         flag_z_d = (alu_result == 32'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else if (!stall) begin
         pc_q     <= pc_d;
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
      end
   end

   assign pc        = pc_q;
   assign taken     = takenSel;
   assign link_we   = (status == ST_JMOR || status == ST_JALM || status == ST_JSPAL) && !stall;
   assign link_data = pc_plus4;
   assign flag_n    = flag_n_q;
   assign flag_z    = flag_z_q;

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  when 1, hold PC and flags.
REQ-005 SHALL have port status  input  3  control class {status2,status1,status0} from the control stage.
REQ-006 SHALL have port alu_result  input  32  ALU output of the current instruction.
REQ-007 SHALL have port alu_zero  input  1  ALU zero flag of the current instruction.
REQ-008 SHALL have port flag_we  input  1  current instruction updates the status flags.
REQ-009 SHALL have port imm  input  32  sign-extended immediate.
REQ-010 SHALL have port rs_data  input  32  register rs read data.
REQ-011 SHALL have port mem_data  input  32  data-memory read word.
REQ-012 SHALL have port pc  output  32  registered program counter.
REQ-013 SHALL have port pc_plus4  output  32  pc+4.
REQ-014 SHALL have port taken  output  1  next PC is not pc_plus4.
REQ-015 SHALL have port link_we  output  1  write link_data to $31 this cycle.
REQ-016 SHALL have port link_data  output  32  return address.
REQ-017 SHALL have ports flag_n, flag_z  output  1 each  registered status flags.

Function
REQ-018 SHALL compute pc_plus4 = pc + 4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-019 SHALL compute br_target = pc_plus4 + (imm << 2) modulo 2^32.
REQ-020 SHALL select next_pc by status: 000 -> pc_plus4; 111 (beq) -> br_target if alu_zero; 001 (bmn) -> mem_data if flag_n; 010 (brz) -> rs_data if flag_z; 011 (bz) -> br_target if flag_z; 100 (jmor), 101 (jalm), 110 (jspal) -> mem_data unconditionally; any untaken condition -> pc_plus4.
REQ-021 SHALL force bits [1:0] of every register- or memory-sourced target (rs_data, mem_data) to 00.
REQ-022 SHALL drive taken combinationally, high exactly when next_pc was selected from a non-pc_plus4 source.
REQ-023 SHALL load pc <= next_pc on each rising clk edge with stall=0, and hold pc when stall=1.
REQ-024 SHALL, on a rising edge with flag_we=1 and stall=0, load flag_z <= (alu_result == 0) and flag_n <= alu_result[31]; otherwise hold the flags.
REQ-025 SHALL evaluate bmn/brz/bz conditions on the flag values registered before the current edge; a simultaneous flag_we on the same instruction updates flags only at that edge.
REQ-026 SHALL drive link_we = (status in {100,101,110}) and not stall, combinationally.
REQ-027 SHALL drive link_data = pc_plus4 regardless of link_we.
REQ-028 SHALL treat the latency from inputs to pc as exactly one clock edge; all other outputs are combinational from pc, flags and inputs.

Reset
REQ-029 SHALL, while rst_n=0, force pc=RESET_PC, flag_n=0, flag_z=0 immediately without waiting for clk.
REQ-030 SHALL, when reset asserts mid-operation (including during stall or a taken jump), discard the pending next_pc and flag update.
REQ-031 SHALL resume with pc=RESET_PC advancing on the first rising edge after rst_n deasserts, provided stall=0.

Verification
REQ-032 Reset then status=000 for 3 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; taken=0.
REQ-033 pc=0x100, status=111, alu_zero=1, imm=0xFFFFFFFE -> next pc=0x0FC, taken=1; same with alu_zero=0 -> pc=0x104, taken=0.
REQ-034 flag_we=1, alu_result=0x80000000 at one edge, then status=001, mem_data=0x00000203 -> flag_n=1, pc=0x200, taken=1.
REQ-035 pc=0x40, status=101, mem_data=0x1000 -> link_we=1, link_data=0x44, next pc=0x1000; repeat with stall=1 -> link_we=0, pc stays 0x40.
REQ-036 flags z=0, instruction status=011 with flag_we=1 and alu_result=0 -> branch not taken this edge, flag_z=1 afterwards.
REQ-037 pc=0xFFFFFFFC, status=000 -> pc=0x0; assert rst_n=0 between edges -> pc=RESET_PC immediately, flags cleared.
